i2c_slave_regif: RTL and testbench

//  I2C target (slave) that answers the i2c_master register-access sequence: START, addr+W, reg ptr, data (write)
//  or START, addr+W, reg ptr, Sr, addr+R, data, NACK, STOP (read). Bridges the bus to a user register port.

---
 rtl/i2c_slave_regif_pkg.sv | 19 +
 rtl/i2c_slave_regif_if.sv | 21 ++
 rtl/i2c_slave_regif_bus_sync.sv | 45 ++++
 rtl/i2c_slave_regif.sv | 165 ++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_regif_pkg.sv
// i2c_pkg: I2C FSM state encoding and bus bit constants shared by the target and master
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_t;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
endpackage

// File: rtl/i2c_slave_regif_if.sv
// i2c_slave_regif_if: I2C pin-level signals plus the user register port of the target
interface i2c_slave_regif_if;
  logic       scl_in;
  logic       sda_in;
  logic       tristate;
  logic       sda_out;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;
  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output tristate, sda_out, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy
  );
  modport master (
    output scl_in, sda_in, reg_rdata,
    input  tristate, sda_out, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy
  );
endinterface

// File: rtl/i2c_slave_regif_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA and produces rise/fall/START/STOP pulses
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  // shift the async lines through the chain and keep one history bit for edge detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end
  // registers reset to the idle-bus level so no edge is seen when reset releases
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end
  assign scl      = scl_sync_q[SYNC_STAGES-1];
  assign sda      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl && !scl_prev_q;
  assign scl_fall = !scl && scl_prev_q;
  assign start    = scl && scl_prev_q && sda_prev_q && !sda;
  assign stop     = scl && scl_prev_q && !sda_prev_q && sda;
endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C register-access target bridging the bus to a user register port
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  i2c_slave_regif_if.slave  bus
);
  logic scl, sda, scl_rise, scl_fall, start, stop;
  i2c_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d, addr_q, addr_d, wdata_q, wdata_d, byte_in;
  logic rw_q, rw_d, ptr_seen_q, ptr_seen_d, load_q, load_d, tristate_q, tristate_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, busy_q, busy_d;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_in(bus.scl_in), .sda_in(bus.sda_in),
    .scl(scl), .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );

  // next-state: bit sampling on rise, SDA updates on fall, START/STOP override everything
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    ptr_seen_d = ptr_seen_q;
    load_d     = rd_en_q;
    tristate_d = tristate_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    byte_in    = {rx_q, sda};
    if (scl_rise) begin
      rx_d  = byte_in[6:0];
      cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
    end
    if (load_q && state_q == ST_RDATA) begin
      tx_d       = bus.reg_rdata;
      tristate_d = scl ? tristate_q : bus.reg_rdata[7];
    end
    case (state_q)
      ST_ADDR: if (scl_rise && cnt_q == 4'd7) begin
        rw_d    = sda;
        state_d = (byte_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
      end
      ST_ADDR_ACK: if (scl_fall) begin
        tristate_d = !tristate_q;
        if (!tristate_q) begin
          cnt_d   = 4'd0;
          state_d = (rw_q == I2C_RW_WRITE) ? (ptr_seen_q ? ST_WDATA : ST_PTR) : ST_RDATA;
          rd_en_d = (rw_q == I2C_RW_READ);
        end
      end
      ST_PTR: if (scl_rise && cnt_q == 4'd7) begin
        addr_d     = byte_in;
        ptr_seen_d = 1'b1;
        state_d    = ST_PTR_ACK;
      end
      ST_PTR_ACK: if (scl_fall) begin
        tristate_d = !tristate_q;
        if (!tristate_q) begin
          cnt_d   = 4'd0;
          state_d = ST_WDATA;
        end
      end
      ST_WDATA: if (scl_rise && cnt_q == 4'd7) begin
        wdata_d = byte_in;
        wr_en_d = 1'b1;
        state_d = ST_WDATA_ACK;
      end
      ST_WDATA_ACK: if (scl_fall) begin
        tristate_d = !tristate_q;
        if (!tristate_q) begin
          cnt_d   = 4'd0;
          addr_d  = addr_q + 8'd1;
          state_d = ST_WDATA;
        end
      end
      ST_RDATA: if (scl_fall) begin
        if (cnt_q == 4'd8) begin
          tristate_d = 1'b1;
          state_d    = ST_RDATA_ACK;
        end else if (cnt_q == 4'd0) begin
          tristate_d = tx_q[7];
        end else begin
          tx_d       = {tx_q[6:0], 1'b1};
          tristate_d = tx_q[6];
        end
      end
      ST_RDATA_ACK: if (scl_rise) begin
        if (sda == I2C_NACK) begin
          state_d = ST_WAIT_STOP;
        end else begin
          cnt_d   = 4'd0;
          addr_d  = addr_q + 8'd1;
          rd_en_d = 1'b1;
          state_d = ST_RDATA;
        end
      end
      default: ;
    endcase
    if (start) begin
      state_d    = ST_ADDR;
      cnt_d      = 4'd0;
      tristate_d = 1'b1;
      busy_d     = 1'b1;
    end
    if (stop) begin
      state_d    = ST_IDLE;
      cnt_d      = 4'd0;
      tristate_d = 1'b1;
      busy_d     = 1'b0;
      ptr_seen_d = 1'b0;
    end
  end

  // state and output registers; reset releases SDA immediately
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'hff;
      rw_q       <= 1'b0;
      ptr_seen_q <= 1'b0;
      load_q     <= 1'b0;
      tristate_q <= 1'b1;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      ptr_seen_q <= ptr_seen_d;
      load_q     <= load_d;
      tristate_q <= tristate_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tristate  = tristate_q;
  assign bus.sda_out   = tristate_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr_en = wr_en_q;
  assign bus.reg_rd_en = rd_en_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: behavioural I2C master with scoreboarded register-port strobes
module tb_i2c_slave_regif;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] mem [256];
  logic [15:0] exp_wr [$];
  logic [7:0] exp_rd [$];
  int errors = 0;
  int checks = 0;
  int drive_cnt = 0;

  always #5 clk = ~clk;

  i2c_slave_regif_if bus();
  i2c_slave_regif #(.SLAVE_ADDR(7'h68), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & (bus.tristate | bus.sda_out);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // register file with one clock of read latency
  always @(posedge clk) begin
    if (bus.reg_rd_en) bus.reg_rdata <= mem[bus.reg_addr];
    if (bus.reg_wr_en) mem[bus.reg_addr] <= bus.reg_wdata;
  end

  // monitor: pops expected strobes whenever the DUT presents one
  always @(negedge clk) begin
    if (!bus.tristate) drive_cnt++;
    if (rst && bus.reg_wr_en && bus.reg_rd_en) check("wr_rd_same_clk", 16'd1, 16'd0);
    if (rst && bus.reg_wr_en) begin
      if (exp_wr.size() == 0) check("unexpected_wr", {bus.reg_addr, bus.reg_wdata}, 16'hdead);
      else check("wr_addr_data", {bus.reg_addr, bus.reg_wdata}, exp_wr.pop_front());
    end
    if (rst && bus.reg_rd_en) begin
      if (exp_rd.size() == 0) check("unexpected_rd", {8'd0, bus.reg_addr}, 16'hdead);
      else check("rd_addr", {8'd0, bus.reg_addr}, {8'd0, exp_rd.pop_front()});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; m_scl = 1'b1; wait_clk(8);
    m_sda = 1'b0; wait_clk(8);
    m_scl = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_rstart;
    m_sda = 1'b1; wait_clk(4);
    m_scl = 1'b1; wait_clk(8);
    m_sda = 1'b0; wait_clk(8);
    m_scl = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wait_clk(4);
    m_scl = 1'b1; wait_clk(8);
    m_sda = 1'b1; wait_clk(8);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_clk(4);
    m_scl = 1'b1; wait_clk(8);
    m_scl = 1'b0; wait_clk(4);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(4);
    m_scl = 1'b1; wait_clk(4);
    b = bus.sda_in; wait_clk(4);
    m_scl = 1'b0; wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  task automatic queues_empty(input string name);
    check({name, "_wr_left"}, 16'(exp_wr.size()), 16'd0);
    check({name, "_rd_left"}, 16'(exp_rd.size()), 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack;
    logic b;
    logic [7:0] d;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hee;
    mem[8'h75] = 8'h68;
    mem[8'h3b] = 8'h12;
    mem[8'h3c] = 8'h34;
    mem[8'h3d] = 8'h56;
    mem[8'h40] = 8'h00;
    bus.reg_rdata = 8'h00;
    wait_clk(4);
    check("rst_tristate", {15'd0, bus.tristate}, 16'd1);
    check("rst_sda_out", {15'd0, bus.sda_out}, 16'd1);
    check("rst_reg_addr", {8'd0, bus.reg_addr}, 16'h0000);
    check("rst_reg_wdata", {8'd0, bus.reg_wdata}, 16'h0000);
    check("rst_strobes", {14'd0, bus.reg_wr_en, bus.reg_rd_en}, 16'd0);
    check("rst_busy", {15'd0, bus.busy}, 16'd0);
    rst = 1'b1;
    wait_clk(20);

    // single write of 0x00 to 0x6B
    i2c_start;
    check("wr1_busy", {15'd0, bus.busy}, 16'd1);
    write_byte(8'hd0, ack); check("wr1_addr_ack", {15'd0, ack}, 16'd0);
    write_byte(8'h6b, ack); check("wr1_ptr_ack", {15'd0, ack}, 16'd0);
    exp_wr.push_back(16'h6b00);
    write_byte(8'h00, ack); check("wr1_data_ack", {15'd0, ack}, 16'd0);
    i2c_stop;
    check("wr1_busy_after", {15'd0, bus.busy}, 16'd0);
    queues_empty("wr1");

    // pointer write then repeated-start read of one byte
    i2c_start;
    write_byte(8'hd0, ack); check("rd1_addr_ack", {15'd0, ack}, 16'd0);
    write_byte(8'h75, ack); check("rd1_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_rstart;
    exp_rd.push_back(8'h75);
    write_byte(8'hd1, ack); check("rd1_addr_r_ack", {15'd0, ack}, 16'd0);
    read_byte(1'b1, d); check("rd1_data", {8'd0, d}, 16'h0068);
    i2c_stop;
    check("rd1_busy_after", {15'd0, bus.busy}, 16'd0);
    queues_empty("rd1");

    // burst read of three bytes from 0x3B
    i2c_start;
    write_byte(8'hd0, ack);
    write_byte(8'h3b, ack); check("brd_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_rstart;
    exp_rd.push_back(8'h3b); exp_rd.push_back(8'h3c); exp_rd.push_back(8'h3d);
    write_byte(8'hd1, ack); check("brd_addr_ack", {15'd0, ack}, 16'd0);
    read_byte(1'b0, d); check("brd_byte0", {8'd0, d}, 16'h0012);
    read_byte(1'b0, d); check("brd_byte1", {8'd0, d}, 16'h0034);
    read_byte(1'b1, d); check("brd_byte2", {8'd0, d}, 16'h0056);
    i2c_stop;
    check("brd_reg_addr_end", {8'd0, bus.reg_addr}, 16'h003d);
    queues_empty("brd");

    // wrong address: never acknowledged, SDA never driven
    d0 = drive_cnt;
    i2c_start;
    write_byte(8'hd2, ack); check("nack_addr", {15'd0, ack}, 16'd1);
    write_byte(8'h55, ack); check("nack_follow", {15'd0, ack}, 16'd1);
    check("nack_busy_before_stop", {15'd0, bus.busy}, 16'd1);
    i2c_stop;
    check("nack_busy_after_stop", {15'd0, bus.busy}, 16'd0);
    check("nack_no_drive", 16'(drive_cnt - d0), 16'd0);
    queues_empty("nack");

    // burst write across the 0xFF -> 0x00 wrap
    i2c_start;
    write_byte(8'hd0, ack);
    write_byte(8'hff, ack); check("bwr_ptr_ack", {15'd0, ack}, 16'd0);
    exp_wr.push_back(16'hffaa);
    write_byte(8'haa, ack); check("bwr_d0_ack", {15'd0, ack}, 16'd0);
    exp_wr.push_back(16'h00bb);
    write_byte(8'hbb, ack); check("bwr_d1_ack", {15'd0, ack}, 16'd0);
    i2c_stop;
    check("bwr_reg_addr_end", {8'd0, bus.reg_addr}, 16'h0001);
    queues_empty("bwr");

    // STOP after four data bits discards the partial byte
    i2c_start;
    write_byte(8'hd0, ack);
    write_byte(8'h10, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop;
    check("pstop_busy", {15'd0, bus.busy}, 16'd0);
    check("pstop_tristate", {15'd0, bus.tristate}, 16'd1);
    check("pstop_reg_addr", {8'd0, bus.reg_addr}, 16'h0010);
    queues_empty("pstop");

    // reset while the target is driving read data
    i2c_start;
    write_byte(8'hd0, ack);
    write_byte(8'h40, ack);
    i2c_rstart;
    exp_rd.push_back(8'h40);
    write_byte(8'hd1, ack);
    read_bit(b); read_bit(b);
    wait_clk(2);
    check("mrst_driving", {15'd0, bus.tristate}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_tristate", {15'd0, bus.tristate}, 16'd1);
    check("mrst_busy", {15'd0, bus.busy}, 16'd0);
    check("mrst_reg_addr", {8'd0, bus.reg_addr}, 16'h0000);
    wait_clk(2);
    rst = 1'b1;
    i2c_stop;
    i2c_start;
    write_byte(8'hd0, ack); check("mrst_again_addr_ack", {15'd0, ack}, 16'd0);
    write_byte(8'h20, ack);
    exp_wr.push_back(16'h2077);
    write_byte(8'h77, ack); check("mrst_again_data_ack", {15'd0, ack}, 16'd0);
    i2c_stop;
    queues_empty("mrst");

    wait_clk(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
